// File: rtl/multiplicador_pkg.sv
// rtl/multiplicador_pkg.sv - shared widths and FSM encoding for the 8x8 shift-and-add multiplier
package multiplicador_pkg;

  localparam int LARG_OP   = 8;
  localparam int LARG_PROD = 16;
  localparam int LARG_ACC  = LARG_PROD + 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

endpackage

// File: rtl/multiplicador8_if.sv
// rtl/multiplicador8_if.sv - start/operand/result bundle for multiplicador8
interface multiplicador8_if;
  import multiplicador_pkg::*;

  logic                 inicio;
  logic [LARG_OP-1:0]   A;
  logic [LARG_OP-1:0]   B;
  logic [LARG_PROD-1:0] P;
  logic                 pronto;
  logic                 ocupado;

  modport master (output inicio, A, B, input P, pronto, ocupado);
  modport slave  (input inicio, A, B, output P, pronto, ocupado);

endinterface

// File: rtl/somador8.sv
// rtl/somador8.sv - 8-bit ripple-carry adder with 9-bit sum
module somador8
  import multiplicador_pkg::*;
(
  input  logic [LARG_OP-1:0] a,
  input  logic [LARG_OP-1:0] b,
  output logic [LARG_OP:0]   s
);

  logic [LARG_OP:0] c;

  always_comb begin
    c = '0;
    s = '0;
    for (int i = 0; i < LARG_OP; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    s[LARG_OP] = c[LARG_OP];
  end

endmodule

// File: rtl/multiplicador8.sv
// rtl/multiplicador8.sv - sequential 8x8 unsigned multiplier, one multiplier bit per cycle, LSB first
module multiplicador8
  import multiplicador_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  multiplicador8_if.slave  bus
);

  estado_t              estado_q, estado_d;
  logic [LARG_ACC-1:0]  acc_q, acc_d;
  logic [LARG_OP-1:0]   m_q, m_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [LARG_PROD-1:0] p_q, p_d;
  logic                 pronto_q, pronto_d;

  logic [LARG_OP-1:0]   parcela;
  logic [LARG_OP:0]     soma;

  // Gating the addend keeps a single adder for both the add and the pass-through case.
  assign parcela = acc_q[0] ? m_q : '0;

  somador8 u_somador (
    .a (acc_q[LARG_PROD-1:LARG_OP]),
    .b (parcela),
    .s (soma)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (bus.inicio) estado_d = CALC;
      CALC:    if (cnt_q == 3'd7) estado_d = FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    bus.ocupado = (estado_q != OCIOSO);
    bus.P       = p_q;
    bus.pronto  = pronto_q;
  end

  always_comb begin
    acc_d    = acc_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    pronto_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          m_d   = bus.A;
          acc_d = {1'b0, {LARG_OP{1'b0}}, bus.B};
          cnt_d = 3'd0;
        end
      end
      CALC: begin
        // The sum carry shifts into bit 15, so the top product bit survives.
        acc_d = {1'b0, soma, acc_q[LARG_OP-1:1]};
        cnt_d = cnt_q + 3'd1;
      end
      FIM: begin
        p_d      = acc_q[LARG_PROD-1:0];
        pronto_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      pronto_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      pronto_q <= pronto_d;
    end
  end

endmodule
